// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 4;

    // in_zero_reg bit positions
    localparam int ZR_A = 3;
    localparam int ZR_B = 2;
    localparam int ZR_C = 1;
    localparam int ZR_D = 0;

    // in_write / wb_en bit positions
    localparam int WR_Y1 = 0;
    localparam int WR_Y2 = 1;
endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Decoder-side, ALU-side and writeback signals of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              in_invalid;
    logic [2:0]        in_alu_op;
    logic [1:0]        in_vec_perci;
    logic              in_alu_form;
    logic              in_const_c;
    logic [DATA_W-1:0] in_constant;
    logic [3:0]        in_zero_reg;
    logic [SEL_W-1:0]  in_sel_a, in_sel_b, in_sel_c, in_sel_d;
    logic [SEL_W-1:0]  in_sel_y1, in_sel_y2;
    logic [1:0]        in_write;

    logic              out_valid;
    logic              out_ready;
    logic              out_invalid;
    logic [2:0]        out_alu_op;
    logic [1:0]        out_vec_perci;
    logic              out_alu_form;
    logic [DATA_W-1:0] out_a, out_b, out_c, out_d;
    logic [SEL_W-1:0]  out_sel_y1, out_sel_y2;
    logic [1:0]        out_write;

    logic [1:0]        wb_en;
    logic [SEL_W-1:0]  wb_sel1, wb_sel2;
    logic [DATA_W-1:0] wb_data1, wb_data2;

    modport slave (
        input  in_valid, in_invalid, in_alu_op, in_vec_perci, in_alu_form,
               in_const_c, in_constant, in_zero_reg, in_sel_a, in_sel_b,
               in_sel_c, in_sel_d, in_sel_y1, in_sel_y2, in_write,
               out_ready, wb_en, wb_sel1, wb_sel2, wb_data1, wb_data2,
        output in_ready, out_valid, out_invalid, out_alu_op, out_vec_perci,
               out_alu_form, out_a, out_b, out_c, out_d, out_sel_y1,
               out_sel_y2, out_write
    );

    modport master (
        output in_valid, in_invalid, in_alu_op, in_vec_perci, in_alu_form,
               in_const_c, in_constant, in_zero_reg, in_sel_a, in_sel_b,
               in_sel_c, in_sel_d, in_sel_y1, in_sel_y2, in_write,
               out_ready, wb_en, wb_sel1, wb_sel2, wb_data1, wb_data2,
        input  in_ready, out_valid, out_invalid, out_alu_op, out_vec_perci,
               out_alu_form, out_a, out_b, out_c, out_d, out_sel_y1,
               out_sel_y2, out_write
    );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : 4-read/2-write register file, r0 hardwired to 0, write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [SEL_W-1:0]  rd_sel  [4],
    output logic      [DATA_W-1:0] rd_data [4],
    input  wire logic [1:0]        wr_en,
    input  wire logic [SEL_W-1:0]  wr_sel1,
    input  wire logic [SEL_W-1:0]  wr_sel2,
    input  wire logic [DATA_W-1:0] wr_data1,
    input  wire logic [DATA_W-1:0] wr_data2
);
    localparam int NREG = 1 << SEL_W;

    logic [DATA_W-1:0] r_regs [NREG];

    // Y2 is written last so it wins when both ports target the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            if (wr_en[WR_Y1] && (wr_sel1 != '0)) r_regs[wr_sel1] <= wr_data1;
            if (wr_en[WR_Y2] && (wr_sel2 != '0)) r_regs[wr_sel2] <= wr_data2;
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_rd
        always_comb begin
            rd_data[p] = r_regs[rd_sel[p]];
            if (rd_sel[p] == '0)
                rd_data[p] = '0;
            else if (wr_en[WR_Y2] && (wr_sel2 == rd_sel[p]))
                rd_data[p] = wr_data2;
            else if (wr_en[WR_Y1] && (wr_sel1 == rd_sel[p]))
                rd_data[p] = wr_data1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand fetch, hazard scoreboard and output register for ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_operand_stage_if.slave bus
);
    localparam int NREG = 1 << SEL_W;

    logic [SEL_W-1:0]  w_rd_sel  [4];
    logic [DATA_W-1:0] w_rd_data [4];
    logic [NREG-1:0]   r_pending, w_clr, w_pend_eff, w_src, w_dst;
    logic              w_hazard, w_ready, w_accept;
    logic [DATA_W-1:0] w_a, w_b, w_c, w_d;

    logic              r_valid, r_invalid, r_alu_form;
    logic [2:0]        r_alu_op;
    logic [1:0]        r_vec_perci, r_write;
    logic [DATA_W-1:0] r_a, r_b, r_c, r_d;
    logic [SEL_W-1:0]  r_sel_y1, r_sel_y2;

    always_comb begin
        w_rd_sel[0] = bus.in_sel_a;
        w_rd_sel[1] = bus.in_sel_b;
        w_rd_sel[2] = bus.in_sel_c;
        w_rd_sel[3] = bus.in_sel_d;
    end

    alu_regfile #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_sel   (w_rd_sel),
        .rd_data  (w_rd_data),
        .wr_en    (bus.wb_en),
        .wr_sel1  (bus.wb_sel1),
        .wr_sel2  (bus.wb_sel2),
        .wr_data1 (bus.wb_data1),
        .wr_data2 (bus.wb_data2)
    );

    // Pending bits are checked after this cycle's writebacks retire them
    always_comb begin
        w_clr = '0;
        if (bus.wb_en[WR_Y1]) w_clr[bus.wb_sel1] = 1'b1;
        if (bus.wb_en[WR_Y2]) w_clr[bus.wb_sel2] = 1'b1;
        w_pend_eff = r_pending & ~w_clr;

        w_src = '0;
        if (!bus.in_zero_reg[ZR_A]) w_src[bus.in_sel_a] = 1'b1;
        if (!bus.in_zero_reg[ZR_B] && !bus.in_const_c) w_src[bus.in_sel_b] = 1'b1;
        if (!bus.in_zero_reg[ZR_C]) w_src[bus.in_sel_c] = 1'b1;
        if (!bus.in_zero_reg[ZR_D] && !bus.in_const_c) w_src[bus.in_sel_d] = 1'b1;
        w_src[0] = 1'b0;

        w_dst = '0;
        if (bus.in_write[WR_Y1]) w_dst[bus.in_sel_y1] = 1'b1;
        if (bus.in_write[WR_Y2]) w_dst[bus.in_sel_y2] = 1'b1;
        w_dst[0] = 1'b0;

        w_hazard = !bus.in_invalid && (|((w_src | w_dst) & w_pend_eff));
        w_ready  = !rst && (!r_valid || bus.out_ready) && !w_hazard;
        w_accept = bus.in_valid && w_ready;
    end

    always_comb begin
        w_a = bus.in_zero_reg[ZR_A] ? '0 : w_rd_data[0];
        w_b = bus.in_zero_reg[ZR_B] ? '0 : w_rd_data[1];
        w_c = bus.in_zero_reg[ZR_C] ? '0 : w_rd_data[2];
        w_d = bus.in_zero_reg[ZR_D] ? '0 : w_rd_data[3];
        if (bus.in_const_c) begin
            w_b = bus.in_constant;
            w_d = '0;
        end
        if (bus.in_invalid) begin
            w_a = '0;
            w_b = '0;
            w_c = '0;
            w_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_valid     <= 1'b0;
            r_invalid   <= 1'b0;
            r_alu_op    <= '0;
            r_vec_perci <= '0;
            r_alu_form  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_sel_y1    <= '0;
            r_sel_y2    <= '0;
            r_write     <= '0;
        end else begin
            r_pending <= w_pend_eff |
                         ((w_accept && !bus.in_invalid) ? w_dst : '0);
            if (w_accept) begin
                r_valid     <= 1'b1;
                r_invalid   <= bus.in_invalid;
                r_alu_op    <= bus.in_alu_op;
                r_vec_perci <= bus.in_vec_perci;
                r_alu_form  <= bus.in_alu_form;
                r_a         <= w_a;
                r_b         <= w_b;
                r_c         <= w_c;
                r_d         <= w_d;
                r_sel_y1    <= bus.in_sel_y1;
                r_sel_y2    <= bus.in_sel_y2;
                r_write     <= bus.in_invalid ? 2'b00 : bus.in_write;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = w_ready;
    assign bus.out_valid     = r_valid;
    assign bus.out_invalid   = r_invalid;
    assign bus.out_alu_op    = r_alu_op;
    assign bus.out_vec_perci = r_vec_perci;
    assign bus.out_alu_form  = r_alu_form;
    assign bus.out_a         = r_a;
    assign bus.out_b         = r_b;
    assign bus.out_c         = r_c;
    assign bus.out_d         = r_d;
    assign bus.out_sel_y1    = r_sel_y1;
    assign bus.out_sel_y2    = r_sel_y2;
    assign bus.out_write     = r_write;
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed vector table plus hazard/backpressure/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_W(32), .SEL_W(4)) bus ();

    alu_operand_stage #(.DATA_W(32), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0]  sa, sb, sc, sd, zr, y1, y2;
        logic        cc;
        logic [31:0] k;
        logic [1:0]  wr;
        logic        inv;
        logic [2:0]  op;
        logic [31:0] ea, eb, ec, ed;
        logic [1:0]  ew;
        logic        einv;
    } vec_t;

    vec_t vt [8];

    // Values preloaded into r1..r15
    function automatic logic [31:0] rv(input int i);
        return (i == 3) ? 32'h1234_5678 : 32'h0F0F_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sa, sb, sc, sd, zr, input logic cc,
                         input logic [31:0] k, input logic [3:0] y1, y2,
                         input logic [1:0] wr, input logic inv, input logic [2:0] op);
        bus.in_valid     = 1'b1;
        bus.in_sel_a     = sa;
        bus.in_sel_b     = sb;
        bus.in_sel_c     = sc;
        bus.in_sel_d     = sd;
        bus.in_zero_reg  = zr;
        bus.in_const_c   = cc;
        bus.in_constant  = k;
        bus.in_sel_y1    = y1;
        bus.in_sel_y2    = y2;
        bus.in_write     = wr;
        bus.in_invalid   = inv;
        bus.in_alu_op    = op;
        bus.in_vec_perci = op[1:0];
        bus.in_alu_form  = op[0];
    endtask

    task automatic wb(input logic [1:0] en, input logic [3:0] s1, input logic [31:0] d1,
                      input logic [3:0] s2, input logic [31:0] d2);
        bus.wb_en    = en;
        bus.wb_sel1  = s1;
        bus.wb_data1 = d1;
        bus.wb_sel2  = s2;
        bus.wb_data2 = d2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{4'd3, 4'd0, 4'd5, 4'd0, 4'b0000, 4'd0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd1,
                  rv(3), 32'h0, rv(5), 32'h0, 2'b00, 1'b0};
        vt[1] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'd0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2,
                  rv(1), rv(2), rv(3), rv(4), 2'b00, 1'b0};
        vt[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 4'd0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd3,
                  32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0};
        vt[3] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'b0101, 4'd0, 4'd0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd4,
                  rv(7), 32'h0, rv(9), 32'h0, 2'b00, 1'b0};
        vt[4] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'b0000, 4'd0, 4'd0, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 3'd5,
                  rv(15), 32'hDEAD_BEEF, rv(13), 32'h0, 2'b00, 1'b0};
        vt[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'd7, 4'd8, 1'b0, 32'h0, 2'b11, 1'b1, 3'd6,
                  32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b1};
        vt[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 1'b0, 32'h0, 2'b01, 1'b0, 3'd7,
                  32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0};
        vt[7] = '{4'd0, 4'd11, 4'd0, 4'd0, 4'b0000, 4'd0, 4'd0, 1'b0, 32'h0, 2'b10, 1'b0, 3'd0,
                  32'h0, rv(11), 32'h0, 32'h0, 2'b10, 1'b0};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wb(2'b00, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_write", 32'(bus.out_write), 0);
        chk("rst_out_a", bus.out_a, 0);
        rst = 1'b0;

        // Preload r1..r15, plus an ignored write to r0
        for (int i = 1; i < 16; i++) begin
            wb(2'b01, 4'(i), rv(i), 0, 0);
            tick();
        end
        wb(2'b01, 4'd0, 32'hFFFF_FFFF, 0, 0);
        tick();
        wb(2'b00, 0, 0, 0, 0);

        // Vector table, one accept per cycle
        for (int v = 0; v < 8; v++) begin
            drive(vt[v].sa, vt[v].sb, vt[v].sc, vt[v].sd, vt[v].zr, vt[v].cc, vt[v].k,
                  vt[v].y1, vt[v].y2, vt[v].wr, vt[v].inv, vt[v].op);
            #1;
            chk($sformatf("v%0d_in_ready", v), 32'(bus.in_ready), 1);
            tick();
            chk($sformatf("v%0d_out_valid", v), 32'(bus.out_valid), 1);
            chk($sformatf("v%0d_out_a", v), bus.out_a, vt[v].ea);
            chk($sformatf("v%0d_out_b", v), bus.out_b, vt[v].eb);
            chk($sformatf("v%0d_out_c", v), bus.out_c, vt[v].ec);
            chk($sformatf("v%0d_out_d", v), bus.out_d, vt[v].ed);
            chk($sformatf("v%0d_out_write", v), 32'(bus.out_write), 32'(vt[v].ew));
            chk($sformatf("v%0d_out_invalid", v), 32'(bus.out_invalid), 32'(vt[v].einv));
            chk($sformatf("v%0d_out_alu_op", v), 32'(bus.out_alu_op), 32'(vt[v].op));
            chk($sformatf("v%0d_out_vec_perci", v), 32'(bus.out_vec_perci), 32'(vt[v].op[1:0]));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 0);

        // Constant form with destination r4, then RAW on r4 released by writeback
        drive(1, 2, 3, 4, 4'b1010, 1, 32'h0003_FFFF, 4, 0, 2'b01, 0, 1);
        tick();
        chk("const_out_a", bus.out_a, 0);
        chk("const_out_b", bus.out_b, 32'h0003_FFFF);
        chk("const_out_c", bus.out_c, 0);
        chk("const_out_d", bus.out_d, 0);
        chk("const_out_write", 32'(bus.out_write), 2'b01);
        chk("const_out_sel_y1", 32'(bus.out_sel_y1), 4);
        drive(4, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 2'b00, 0, 2);
        #1;
        chk("sb4_stall", 32'(bus.in_ready), 0);
        tick();
        chk("sb4_stall2", 32'(bus.in_ready), 0);
        wb(2'b01, 4, 32'h55AA_55AA, 0, 0);
        #1;
        chk("sb4_release", 32'(bus.in_ready), 1);
        tick();
        wb(2'b00, 0, 0, 0, 0);
        chk("sb4_bypass", bus.out_a, 32'h55AA_55AA);

        // RAW on r6 through Y2 writeback port
        drive(0, 0, 0, 0, 4'b1111, 0, 0, 6, 0, 2'b01, 0, 3);
        tick();
        drive(6, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 2'b00, 0, 4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("raw6_stall%0d", i), 32'(bus.in_ready), 0);
            tick();
        end
        wb(2'b10, 0, 0, 6, 32'hCAFE_F00D);
        #1;
        chk("raw6_release", 32'(bus.in_ready), 1);
        tick();
        wb(2'b00, 0, 0, 0, 0);
        chk("raw6_out_valid", 32'(bus.out_valid), 1);
        chk("raw6_bypass", bus.out_a, 32'hCAFE_F00D);

        // WAW on r10
        drive(0, 0, 0, 0, 4'b1111, 0, 0, 10, 0, 2'b01, 0, 5);
        tick();
        drive(0, 0, 0, 0, 4'b1111, 0, 0, 0, 10, 2'b10, 0, 6);
        #1;
        chk("waw10_stall", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        wb(2'b01, 10, 32'h0, 0, 0);
        tick();
        wb(2'b00, 0, 0, 0, 0);

        // Backpressure: bundle held for 5 cycles
        bus.out_ready = 1'b0;
        drive(1, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 2'b00, 0, 7);
        tick();
        drive(2, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 0);
            chk($sformatf("bp_out_a%0d", i), bus.out_a, rv(1));
            chk($sformatf("bp_out_valid%0d", i), 32'(bus.out_valid), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(bus.in_ready), 1);
        tick();
        chk("bp_next_a", bus.out_a, rv(2));

        // Invalid instruction sets no scoreboard bits
        drive(1, 2, 3, 4, 4'b0000, 0, 0, 7, 8, 2'b11, 1, 1);
        tick();
        chk("inv_out_invalid", 32'(bus.out_invalid), 1);
        chk("inv_out_write", 32'(bus.out_write), 0);
        chk("inv_out_a", bus.out_a, 0);
        drive(7, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 2'b00, 0, 2);
        #1;
        chk("inv_no_stall", 32'(bus.in_ready), 1);
        tick();
        chk("inv_follow_a", bus.out_a, rv(7));
        chk("inv_follow_invalid", 32'(bus.out_invalid), 0);

        // Reset mid-operation: r9 pending, bundle held
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 4'b1111, 0, 0, 9, 0, 2'b01, 0, 3);
        tick();
        bus.in_valid = 1'b0;
        chk("mid_out_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_out_write", 32'(bus.out_write), 0);
        drive(9, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 2'b00, 0, 4);
        #1;
        chk("mid_rst_no_stall", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("mid_rst_r9_zero", bus.out_a, 0);
        chk("mid_rst_out_valid2", 32'(bus.out_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
